// File: rtl/stage_if.sv
// Instruction fetch stage: owns the fetch PC, issues single Wishbone reads and
// hands instruction/pc/valid to decode, with a one-entry skid buffer for stalls.
module stage_if #(
  parameter logic [31:0] RESET_ADDR = 32'h8000_0000,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] iwbm_addr_o,
  output logic        iwbm_cyc_o,
  output logic        iwbm_stb_o,
  input  logic [31:0] iwbm_dat_i,
  input  logic        iwbm_ack_i,
  input  logic        iwbm_err_i,
  input  logic        stall_i,
  input  logic        take_branch_i,
  input  logic [31:0] pc_target_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  output logic        e_inst_access_fault_o,
  output logic        e_inst_addr_misaligned_o
);

  typedef enum logic [1:0] {S_REQ, S_HOLD, S_DISCARD, S_FAULT} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc_q;
  logic [31:0] r_instr;
  logic [31:0] r_pc_o;
  logic        r_valid;
  logic        r_e_fault;
  logic        r_e_mis;
  logic [31:0] r_buf_instr;
  logic [31:0] r_buf_pc;
  logic        r_buf_fault;
  logic [31:0] r_pend_pc;
  logic        r_pend_mis;
  logic        w_busy;
  logic        w_done;
  logic        w_open;
  logic        w_mis;
  logic        w_cyc;

  assign w_busy = (r_state == S_REQ) || (r_state == S_DISCARD);
  assign w_done = iwbm_ack_i | iwbm_err_i;
  // A bus cycle that does not terminate this clock must be drained before redirecting.
  assign w_open = w_busy && !w_done;
  assign w_mis  = (pc_target_i[1:0] != 2'b00);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_REQ;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (take_branch_i) begin
      if (w_open)     w_state_nxt = S_DISCARD;
      else if (w_mis) w_state_nxt = S_FAULT;
      else            w_state_nxt = S_REQ;
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_done) begin
            if (stall_i)         w_state_nxt = S_HOLD;
            else if (iwbm_err_i) w_state_nxt = S_FAULT;
            else                 w_state_nxt = S_REQ;
          end
        end
        S_HOLD: begin
          if (!stall_i) w_state_nxt = r_buf_fault ? S_FAULT : S_REQ;
        end
        S_DISCARD: begin
          if (w_done) w_state_nxt = r_pend_mis ? S_FAULT : S_REQ;
        end
        default: w_state_nxt = S_FAULT;
      endcase
    end
  end

  // Reset aborts the bus cycle combinationally.
  always_comb begin
    w_cyc = 1'b0;
    if (rst_i && w_busy) w_cyc = 1'b1;
  end

  assign iwbm_cyc_o  = w_cyc;
  assign iwbm_stb_o  = w_cyc;
  assign iwbm_addr_o = r_pc_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pc_q    <= RESET_ADDR;
      r_instr   <= NOP_INST;
      r_pc_o    <= 32'h0;
      r_valid   <= 1'b0;
      r_e_fault <= 1'b0;
      r_e_mis   <= 1'b0;
    end else if (take_branch_i) begin
      r_instr   <= NOP_INST;
      r_valid   <= 1'b0;
      r_e_fault <= 1'b0;
      r_e_mis   <= 1'b0;
      if (!w_open) begin
        if (w_mis) begin
          r_pc_o  <= pc_target_i;
          r_valid <= 1'b1;
          r_e_mis <= 1'b1;
        end else begin
          r_pc_q <= pc_target_i;
        end
      end
    end else begin
      case (r_state)
        S_REQ: begin
          if (iwbm_ack_i && !iwbm_err_i) r_pc_q <= r_pc_q + 32'd4;
          if (!stall_i) begin
            if (iwbm_err_i) begin
              r_instr   <= NOP_INST;
              r_pc_o    <= r_pc_q;
              r_valid   <= 1'b1;
              r_e_fault <= 1'b1;
            end else if (iwbm_ack_i) begin
              r_instr <= iwbm_dat_i;
              r_pc_o  <= r_pc_q;
              r_valid <= 1'b1;
            end else begin
              r_valid <= 1'b0;
            end
          end
        end
        S_HOLD: begin
          if (!stall_i) begin
            r_instr   <= r_buf_instr;
            r_pc_o    <= r_buf_pc;
            r_valid   <= 1'b1;
            r_e_fault <= r_buf_fault;
          end
        end
        S_DISCARD: begin
          if (w_done) begin
            if (r_pend_mis) begin
              r_pc_o  <= r_pend_pc;
              r_valid <= 1'b1;
              r_e_mis <= 1'b1;
            end else begin
              r_pc_q <= r_pend_pc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Skid buffer and pending redirect target; only read in the states that load them.
  always_ff @(posedge clk_i) begin
    if (take_branch_i) begin
      r_pend_pc  <= pc_target_i;
      r_pend_mis <= w_mis;
    end
    if (!take_branch_i && (r_state == S_REQ) && stall_i && w_done) begin
      r_buf_instr <= iwbm_err_i ? NOP_INST : iwbm_dat_i;
      r_buf_pc    <= r_pc_q;
      r_buf_fault <= iwbm_err_i;
    end
  end

  assign instruction_o            = r_instr;
  assign pc_o                     = r_pc_o;
  assign valid_o                  = r_valid;
  assign e_inst_access_fault_o    = r_e_fault;
  assign e_inst_addr_misaligned_o = r_e_mis;

endmodule

// File: tb/tb_stage_if.sv
// Scoreboard bench for stage_if: directed scenarios push expected decode-side
// transfers and per-cycle signal expectations; one monitor process compares them.
module tb_stage_if;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int S_CYC = 0, S_STB = 1, S_ADDR = 2, S_VALID = 3, S_PC = 4;
  localparam int S_INS = 5, S_FLT = 6, S_MIS = 7, S_QSZ = 8;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] iwbm_addr_o;
  logic        iwbm_cyc_o;
  logic        iwbm_stb_o;
  logic [31:0] iwbm_dat_i;
  logic        iwbm_ack_i;
  logic        iwbm_err_i;
  logic        stall_i;
  logic        take_branch_i;
  logic [31:0] pc_target_i;
  logic [31:0] instruction_o;
  logic [31:0] pc_o;
  logic        valid_o;
  logic        e_inst_access_fault_o;
  logic        e_inst_addr_misaligned_o;

  always #5 clk = ~clk;

  stage_if dut (
    .clk_i(clk), .rst_i(rst_i),
    .iwbm_addr_o(iwbm_addr_o), .iwbm_cyc_o(iwbm_cyc_o), .iwbm_stb_o(iwbm_stb_o),
    .iwbm_dat_i(iwbm_dat_i), .iwbm_ack_i(iwbm_ack_i), .iwbm_err_i(iwbm_err_i),
    .stall_i(stall_i), .take_branch_i(take_branch_i), .pc_target_i(pc_target_i),
    .instruction_o(instruction_o), .pc_o(pc_o), .valid_o(valid_o),
    .e_inst_access_fault_o(e_inst_access_fault_o),
    .e_inst_addr_misaligned_o(e_inst_addr_misaligned_o)
  );

  // Slave: ws wait states, data = ~addr, optional error / marker address.
  int          ws = 0;
  int          cnt = 0;
  logic [31:0] err_addr = 32'h1;
  logic [31:0] dead_addr = 32'h1;
  logic        w_hit;
  assign w_hit      = iwbm_cyc_o && (cnt >= ws);
  assign iwbm_ack_i = w_hit && (iwbm_addr_o != err_addr);
  assign iwbm_err_i = w_hit && (iwbm_addr_o == err_addr);
  assign iwbm_dat_i = (iwbm_addr_o == dead_addr) ? 32'hDEAD_BEEF : ~iwbm_addr_o;
  always @(posedge clk) begin
    if (!iwbm_cyc_o || iwbm_ack_i || iwbm_err_i) cnt <= 0;
    else cnt <= cnt + 1;
  end

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        flt;
    logic        mis;
  } exp_t;
  typedef struct {
    string       name;
    int          sig;
    logic [31:0] val;
  } dchk_t;

  exp_t  q[$];
  dchk_t dq[$];
  int    checks = 0;
  int    errors = 0;

  task automatic push(input logic [31:0] pc, input logic [31:0] ins, input logic f, input logic m);
    exp_t e;
    e.pc = pc; e.ins = ins; e.flt = f; e.mis = m;
    q.push_back(e);
  endtask

  task automatic ex(input string name, input int sig, input logic [31:0] val);
    dchk_t d;
    d.name = name; d.sig = sig; d.val = val;
    dq.push_back(d);
  endtask

  function automatic logic [31:0] sample(input int s);
    case (s)
      S_CYC:   return {31'b0, iwbm_cyc_o};
      S_STB:   return {31'b0, iwbm_stb_o};
      S_ADDR:  return iwbm_addr_o;
      S_VALID: return {31'b0, valid_o};
      S_PC:    return pc_o;
      S_INS:   return instruction_o;
      S_FLT:   return {31'b0, e_inst_access_fault_o};
      S_MIS:   return {31'b0, e_inst_addr_misaligned_o};
      S_QSZ:   return 32'(q.size());
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Monitor: per-cycle expectations, then scoreboard pop on each accepted transfer.
  logic  exc_prev = 1'b0;
  logic  m_exc;
  exp_t  m_e;
  dchk_t m_d;
  logic [31:0] m_act;
  always @(negedge clk) begin
    while (dq.size() > 0) begin
      m_d = dq.pop_front();
      m_act = sample(m_d.sig);
      checks++;
      if (m_act !== m_d.val) begin
        errors++;
        $display("FAIL %s: got %h, required %h", m_d.name, m_act, m_d.val);
      end
    end
    m_exc = e_inst_access_fault_o | e_inst_addr_misaligned_o;
    if (rst_i && valid_o && !stall_i && !(exc_prev && m_exc)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got pc=%h ins=%h, required no transfer", pc_o, instruction_o);
      end else begin
        m_e = q.pop_front();
        if (pc_o !== m_e.pc || instruction_o !== m_e.ins ||
            e_inst_access_fault_o !== m_e.flt || e_inst_addr_misaligned_o !== m_e.mis) begin
          errors++;
          $display("FAIL sb_transfer: got pc=%h ins=%h flt=%b mis=%b, required pc=%h ins=%h flt=%b mis=%b",
                   pc_o, instruction_o, e_inst_access_fault_o, e_inst_addr_misaligned_o,
                   m_e.pc, m_e.ins, m_e.flt, m_e.mis);
        end
      end
    end
    exc_prev = rst_i && valid_o && m_exc;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    stall_i = 1'b0;
    take_branch_i = 1'b0;
    ex("rst_cyc", S_CYC, 32'h0);
    ex("rst_stb", S_STB, 32'h0);
    ex("rst_valid", S_VALID, 32'h0);
    ex("rst_ins", S_INS, NOP);
    ex("rst_pc", S_PC, 32'h0);
    ex("rst_flt", S_FLT, 32'h0);
    ex("rst_mis", S_MIS, 32'h0);
    ex("rst_addr", S_ADDR, 32'h8000_0000);
    ex("sb_drained", S_QSZ, 32'h0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b0; stall_i = 1'b0; take_branch_i = 1'b0; pc_target_i = 32'h0;
    tick();
    do_reset();

    // Zero-wait streaming
    ws = 0;
    push(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0);
    push(32'h8000_0004, 32'h7FFF_FFFB, 1'b0, 1'b0);
    push(32'h8000_0008, 32'h7FFF_FFF7, 1'b0, 1'b0);
    rst_i = 1'b1;
    ex("s1_addr0", S_ADDR, 32'h8000_0000); ex("s1_cyc0", S_CYC, 32'h1);
    tick(); ex("s1_addr1", S_ADDR, 32'h8000_0004); ex("s1_valid1", S_VALID, 32'h1);
    tick(); ex("s1_addr2", S_ADDR, 32'h8000_0008); ex("s1_valid2", S_VALID, 32'h1);
    tick(); ex("s1_addr3", S_ADDR, 32'h8000_000C); ex("s1_valid3", S_VALID, 32'h1);
    tick(); do_reset();

    // Two wait states, stall on ack of 8000_0004
    ws = 2;
    push(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0);
    push(32'h8000_0004, 32'h7FFF_FFFB, 1'b0, 1'b0);
    rst_i = 1'b1;
    repeat (5) tick();
    stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      ex("s2_hold_cyc", S_CYC, 32'h0); ex("s2_hold_valid", S_VALID, 32'h0);
      ex("s2_hold_pc", S_PC, 32'h8000_0000); ex("s2_hold_ins", S_INS, 32'h7FFF_FFFF);
    end
    tick(); stall_i = 1'b0;
    ex("s2_rel_cyc", S_CYC, 32'h0); ex("s2_rel_valid", S_VALID, 32'h0);
    tick();
    ex("s2_buf_valid", S_VALID, 32'h1); ex("s2_buf_pc", S_PC, 32'h8000_0004);
    ex("s2_next_cyc", S_CYC, 32'h1); ex("s2_next_addr", S_ADDR, 32'h8000_0008);
    tick(); do_reset();

    // Redirect while 8000_0008 is outstanding; its data must be dropped
    ws = 2; dead_addr = 32'h8000_0008;
    push(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0);
    push(32'h8000_0004, 32'h7FFF_FFFB, 1'b0, 1'b0);
    push(32'h8000_0100, 32'h7FFF_FEFF, 1'b0, 1'b0);
    rst_i = 1'b1;
    repeat (6) tick();
    take_branch_i = 1'b1; pc_target_i = 32'h8000_0100;
    tick(); take_branch_i = 1'b0;
    ex("s3_disc_valid", S_VALID, 32'h0); ex("s3_disc_ins", S_INS, NOP);
    ex("s3_disc_cyc", S_CYC, 32'h1); ex("s3_disc_addr", S_ADDR, 32'h8000_0008);
    tick();
    ex("s3_ack_valid", S_VALID, 32'h0); ex("s3_ack_addr", S_ADDR, 32'h8000_0008);
    tick();
    ex("s3_tgt_ins", S_INS, NOP); ex("s3_tgt_valid", S_VALID, 32'h0);
    ex("s3_tgt_addr", S_ADDR, 32'h8000_0100);
    tick(); ex("s3_w1_ins", S_INS, NOP); ex("s3_w1_valid", S_VALID, 32'h0);
    tick(); ex("s3_w2_ins", S_INS, NOP); ex("s3_w2_valid", S_VALID, 32'h0);
    tick(); ex("s3_tgt_out", S_VALID, 32'h1);
    tick(); do_reset(); dead_addr = 32'h1;

    // Redirect coincident with ack and stall
    ws = 0;
    push(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0);
    push(32'h8000_0300, 32'h7FFF_FCFF, 1'b0, 1'b0);
    rst_i = 1'b1;
    tick(); tick();
    take_branch_i = 1'b1; pc_target_i = 32'h8000_0300; stall_i = 1'b1;
    ex("s4_shown_pc", S_PC, 32'h8000_0004);
    tick(); take_branch_i = 1'b0; stall_i = 1'b0;
    ex("s4_flush_valid", S_VALID, 32'h0); ex("s4_tgt_addr", S_ADDR, 32'h8000_0300);
    ex("s4_tgt_cyc", S_CYC, 32'h1);
    tick(); ex("s4_tgt_pc", S_PC, 32'h8000_0300);
    tick(); do_reset();

    // Bus error on 8000_000C, then recovery by redirect
    ws = 0; err_addr = 32'h8000_000C;
    push(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0);
    push(32'h8000_0004, 32'h7FFF_FFFB, 1'b0, 1'b0);
    push(32'h8000_0008, 32'h7FFF_FFF7, 1'b0, 1'b0);
    push(32'h8000_000C, NOP, 1'b1, 1'b0);
    push(32'h8000_0200, 32'h7FFF_FDFF, 1'b0, 1'b0);
    rst_i = 1'b1;
    repeat (4) tick();
    ex("s5_f_cyc", S_CYC, 32'h0); ex("s5_f_flt", S_FLT, 32'h1); ex("s5_f_valid", S_VALID, 32'h1);
    tick(); stall_i = 1'b1;
    ex("s5_hold_cyc", S_CYC, 32'h0); ex("s5_hold_pc", S_PC, 32'h8000_000C); ex("s5_hold_ins", S_INS, NOP);
    tick(); stall_i = 1'b0; take_branch_i = 1'b1; pc_target_i = 32'h8000_0200;
    ex("s5_idle_cyc", S_CYC, 32'h0); ex("s5_idle_flt", S_FLT, 32'h1);
    tick(); take_branch_i = 1'b0;
    ex("s5_clr_flt", S_FLT, 32'h0); ex("s5_clr_valid", S_VALID, 32'h0);
    ex("s5_new_cyc", S_CYC, 32'h1); ex("s5_new_addr", S_ADDR, 32'h8000_0200);
    tick();
    tick(); do_reset(); err_addr = 32'h1;

    // Misaligned redirect, then reset in the middle of a wait
    ws = 0;
    push(32'h8000_0102, NOP, 1'b0, 1'b1);
    rst_i = 1'b1; take_branch_i = 1'b1; pc_target_i = 32'h8000_0102;
    tick(); take_branch_i = 1'b0;
    ex("s6_mis_cyc", S_CYC, 32'h0); ex("s6_mis_flag", S_MIS, 32'h1);
    tick();
    ex("s6_mis_cyc2", S_CYC, 32'h0); ex("s6_mis_pc", S_PC, 32'h8000_0102); ex("s6_mis_valid", S_VALID, 32'h1);
    tick(); ws = 2; take_branch_i = 1'b1; pc_target_i = 32'h8000_0400;
    tick(); take_branch_i = 1'b0;
    ex("s6_wait_cyc", S_CYC, 32'h1); ex("s6_wait_addr", S_ADDR, 32'h8000_0400);
    ex("s6_wait_mis", S_MIS, 32'h0); ex("s6_wait_valid", S_VALID, 32'h0);
    tick(); do_reset();

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
